// File: rtl/tape_cell_ctrl.sv
// -----------------------------------------------------------------------------
// tape_cell_ctrl
// Working-register cache for the tape cell under the head. INC/DEC/LOAD run in
// one cycle on the cached value. Head moves and flushes write the dirty cell
// back and fetch the new cell over a req/ack memory handshake.
//
// Optional feature: define TAPE_CELL_SAT_EN to make INC/DEC saturate
// (INC clamps at all-ones, DEC clamps at zero) instead of wrapping.
//
// Parameters
//   WIDTH      cell / working-register width
//   ADDR_W     tape address width
//   ADDR_RESET head address after reset
//   STEP       INC/DEC magnitude (< 2^WIDTH)
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd                   0 NOP,1 INC,2 DEC,3 MVR,4 MVL,5 LOAD,6 FLUSH,7 NOP
//   load_data             LOAD operand
//   reg_value, zero       cached cell value and its zero flag (zero is comb)
//   dirty                 cache differs from memory
//   head_addr             current head address
//   mem_req/mem_we/mem_addr/mem_wdata   memory request (we=1 write-back)
//   mem_ack/mem_rdata     request completion and fetch data
// -----------------------------------------------------------------------------
module tape_cell_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned ADDR_RESET = 0,
   parameter int unsigned STEP       = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd,
   input  logic [WIDTH-1:0]  load_data,
   output logic [WIDTH-1:0]  reg_value,
   output logic              zero,
   output logic              dirty,
   output logic [ADDR_W-1:0] head_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic              mem_ack,
   input  logic [WIDTH-1:0]  mem_rdata
);

   localparam logic [WIDTH-1:0]  STEP_W   = WIDTH'(STEP);
   localparam logic [ADDR_W-1:0] HEAD_RST = ADDR_W'(ADDR_RESET);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   localparam logic [2:0] CMD_INC   = 3'd1;
   localparam logic [2:0] CMD_DEC   = 3'd2;
   localparam logic [2:0] CMD_MVR   = 3'd3;
   localparam logic [2:0] CMD_MVL   = 3'd4;
   localparam logic [2:0] CMD_LOAD  = 3'd5;
   localparam logic [2:0] CMD_FLUSH = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WB    = 2'd1,
      ST_FETCH = 2'd2
   } state_t;

   state_t            state;
   logic              wb_from_move;   // write-back is followed by a fetch
   logic [WIDTH-1:0]  inc_val_c;
   logic [WIDTH-1:0]  dec_val_c;
   logic [ADDR_W-1:0] head_step_c;

   assign zero = (reg_value == '0);

   // Arithmetic results for INC/DEC (wrap or saturate)
`ifdef TAPE_CELL_SAT_EN
   logic [WIDTH:0] inc_sum_c;

   always_comb begin
      inc_sum_c = {1'b0, reg_value} + {1'b0, STEP_W};
      inc_val_c = inc_sum_c[WIDTH] ? '1 : inc_sum_c[WIDTH-1:0];
      dec_val_c = (reg_value < STEP_W) ? '0 : (reg_value - STEP_W);
   end
`else
   always_comb begin
      inc_val_c = reg_value + STEP_W;
      dec_val_c = reg_value - STEP_W;
   end
`endif

   // Neighbouring head address for MVR/MVL, wrapping modulo 2^ADDR_W
   always_comb begin
      head_step_c = (cmd == CMD_MVR) ? (head_addr + ADDR_ONE) : (head_addr - ADDR_ONE);
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cmd_ready    <= 1'b1;
         wb_from_move <= 1'b0;
         reg_value    <= '0;
         dirty        <= 1'b0;
         head_addr    <= HEAD_RST;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (cmd)
                     CMD_INC: begin
                        reg_value <= inc_val_c;
                        dirty     <= 1'b1;
                     end
                     CMD_DEC: begin
                        reg_value <= dec_val_c;
                        dirty     <= 1'b1;
                     end
                     CMD_LOAD: begin
                        reg_value <= load_data;
                        dirty     <= 1'b1;
                     end
                     CMD_MVR, CMD_MVL: begin
                        // Head moves now; memory sees the old address for
                        // the write-back and the new one for the fetch.
                        head_addr <= head_step_c;
                        mem_req   <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (dirty) begin
                           state        <= ST_WB;
                           wb_from_move <= 1'b1;
                           mem_we       <= 1'b1;
                           mem_addr     <= head_addr;
                           mem_wdata    <= reg_value;
                        end else begin
                           state    <= ST_FETCH;
                           mem_we   <= 1'b0;
                           mem_addr <= head_step_c;
                        end
                     end
                     CMD_FLUSH: begin
                        if (dirty) begin
                           state        <= ST_WB;
                           wb_from_move <= 1'b0;
                           cmd_ready    <= 1'b0;
                           mem_req      <= 1'b1;
                           mem_we       <= 1'b1;
                           mem_addr     <= head_addr;
                           mem_wdata    <= reg_value;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            ST_WB: begin
               if (mem_ack) begin
                  dirty <= 1'b0;
                  if (wb_from_move) begin
                     // mem_req stays high straight into the fetch
                     state    <= ST_FETCH;
                     mem_we   <= 1'b0;
                     mem_addr <= head_addr;
                  end else begin
                     state     <= ST_IDLE;
                     cmd_ready <= 1'b1;
                     mem_req   <= 1'b0;
                     mem_we    <= 1'b0;
                  end
               end
            end

            ST_FETCH: begin
               if (mem_ack) begin
                  reg_value <= mem_rdata;
                  dirty     <= 1'b0;
                  state     <= ST_IDLE;
                  cmd_ready <= 1'b1;
                  mem_req   <= 1'b0;
               end
            end

            default: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
               mem_req   <= 1'b0;
               mem_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tape_cell_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tape_cell_ctrl
// Directed bench for tape_cell_ctrl with default parameters (WIDTH=8,
// ADDR_W=16, ADDR_RESET=0, STEP=1). Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tape_cell_ctrl;

   localparam logic [2:0] NOP   = 3'd0;
   localparam logic [2:0] INC   = 3'd1;
   localparam logic [2:0] DEC   = 3'd2;
   localparam logic [2:0] MVR   = 3'd3;
   localparam logic [2:0] MVL   = 3'd4;
   localparam logic [2:0] LOAD  = 3'd5;
   localparam logic [2:0] FLUSH = 3'd6;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd;
   logic [7:0]  load_data;
   logic [7:0]  reg_value;
   logic        zero;
   logic        dirty;
   logic [15:0] head_addr;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   int tests_run;
   int tests_failed;
   int fetch_cnt;
   int wb_cnt;
   int fetch_base;

   tape_cell_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .load_data (load_data),
      .reg_value (reg_value),
      .zero      (zero),
      .dirty     (dirty),
      .head_addr (head_addr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Completed memory transactions, by type
   always @(posedge clk) begin
      if (rst_n && mem_req && mem_ack) begin
         if (mem_we) wb_cnt++;
         else        fetch_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offer one command for one edge; returns on the following falling edge
   task automatic issue(input logic [2:0] c, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd       = c;
      load_data = d;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = NOP;
   endtask

   // Acknowledge the pending request at the next edge
   task automatic ack(input logic [7:0] d);
      mem_ack   = 1'b1;
      mem_rdata = d;
      @(posedge clk);
      @(negedge clk);
      mem_ack   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      mem_ack   = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      fetch_cnt    = 0;
      wb_cnt       = 0;
      rst_n        = 1'b0;
      cmd_valid    = 1'b0;
      cmd          = NOP;
      load_data    = 8'h00;
      mem_ack      = 1'b0;
      mem_rdata    = 8'h00;

      // Reset values
      @(negedge clk);
      check("rst_reg",   32'(reg_value), 32'h0);
      check("rst_dirty", 32'(dirty),     32'h0);
      check("rst_head",  32'(head_addr), 32'h0);
      check("rst_req",   32'(mem_req),   32'h0);
      check("rst_we",    32'(mem_we),    32'h0);
      check("rst_addr",  32'(mem_addr),  32'h0);
      check("rst_wdata", 32'(mem_wdata), 32'h0);
      check("rst_ready", 32'(cmd_ready), 32'h1);
      check("rst_zero",  32'(zero),      32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // INC x3 back to back
      cmd_valid = 1'b1;
      cmd       = INC;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("inc_ready", 32'(cmd_ready), 32'h1);
         check("inc_noreq", 32'(mem_req),   32'h0);
         check("inc_val",   32'(reg_value), 32'(i + 1));
      end
      cmd_valid = 1'b0;
      cmd       = NOP;
      check("inc_dirty", 32'(dirty), 32'h1);
      check("inc_zero",  32'(zero),  32'h0);

      // FLUSH while dirty, ack held off 4 cycles; an INC offered meanwhile is refused
      fetch_base = fetch_cnt;
      issue(FLUSH, 8'h00);
      cmd_valid = 1'b1;
      cmd       = INC;
      for (int i = 0; i < 4; i++) begin
         check("fl_req",   32'(mem_req),   32'h1);
         check("fl_we",    32'(mem_we),    32'h1);
         check("fl_addr",  32'(mem_addr),  32'h0);
         check("fl_wdata", 32'(mem_wdata), 32'h3);
         check("fl_busy",  32'(cmd_ready), 32'h0);
         check("fl_hold",  32'(reg_value), 32'h3);
         @(posedge clk);
         @(negedge clk);
      end
      ack(8'hEE);
      cmd_valid = 1'b0;
      cmd       = NOP;
      check("fl_dirty",  32'(dirty),     32'h0);
      check("fl_reqlo",  32'(mem_req),   32'h0);
      check("fl_ready",  32'(cmd_ready), 32'h1);
      check("fl_reg",    32'(reg_value), 32'h3);
      @(posedge clk);
      @(negedge clk);
      check("fl_nofetch", 32'(fetch_cnt - fetch_base), 32'h0);
      check("fl_idle",    32'(mem_req),   32'h0);

      // Clean MVR from address 0
      do_reset();
      fetch_base = fetch_cnt;
      issue(MVR, 8'h00);
      check("mvr_req",   32'(mem_req),   32'h1);
      check("mvr_we",    32'(mem_we),    32'h0);
      check("mvr_addr",  32'(mem_addr),  32'h1);
      check("mvr_head",  32'(head_addr), 32'h1);
      check("mvr_busy",  32'(cmd_ready), 32'h0);
      ack(8'h2A);
      check("mvr_reg",   32'(reg_value), 32'h2A);
      check("mvr_dirty", 32'(dirty),     32'h0);
      check("mvr_reqlo", 32'(mem_req),   32'h0);
      check("mvr_ready", 32'(cmd_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      check("mvr_onefetch", 32'(fetch_cnt - fetch_base), 32'h1);

      // LOAD then dirty MVL at head 0 wraps to 0xFFFF
      do_reset();
      issue(LOAD, 8'h55);
      check("ld_reg",   32'(reg_value), 32'h55);
      check("ld_dirty", 32'(dirty),     32'h1);
      issue(MVL, 8'h00);
      check("mvl_wb_req",   32'(mem_req),   32'h1);
      check("mvl_wb_we",    32'(mem_we),    32'h1);
      check("mvl_wb_addr",  32'(mem_addr),  32'h0);
      check("mvl_wb_wdata", 32'(mem_wdata), 32'h55);
      check("mvl_head",     32'(head_addr), 32'hFFFF);
      ack(8'h00);
      check("mvl_f_req",   32'(mem_req),  32'h1);
      check("mvl_f_we",    32'(mem_we),   32'h0);
      check("mvl_f_addr",  32'(mem_addr), 32'hFFFF);
      check("mvl_f_dirty", 32'(dirty),    32'h0);
      ack(8'h11);
      check("mvl_reg",   32'(reg_value), 32'h11);
      check("mvl_reqlo", 32'(mem_req),   32'h0);
      check("mvl_ready", 32'(cmd_ready), 32'h1);

      // Boundary DEC at 0 and INC at 0xFF
      do_reset();
      issue(DEC, 8'h00);
`ifdef TAPE_CELL_SAT_EN
      check("dec_sat",  32'(reg_value), 32'h00);
      check("dec_zero", 32'(zero),      32'h1);
`else
      check("dec_wrap", 32'(reg_value), 32'hFF);
      check("dec_zero", 32'(zero),      32'h0);
`endif
      check("dec_dirty", 32'(dirty), 32'h1);
      issue(LOAD, 8'hFF);
      issue(INC, 8'h00);
`ifdef TAPE_CELL_SAT_EN
      check("inc_sat",   32'(reg_value), 32'hFF);
      check("inc_zero2", 32'(zero),      32'h0);
`else
      check("inc_wrap",  32'(reg_value), 32'h00);
      check("inc_zero2", 32'(zero),      32'h1);
`endif

      // Reset during the fetch of a dirty move
      do_reset();
      issue(LOAD, 8'h77);
      issue(MVR, 8'h00);
      ack(8'h00);
      check("rm_infetch", 32'(mem_req), 32'h1);
      check("rm_fwe",     32'(mem_we),  32'h0);
      rst_n = 1'b0;
      #1;
      check("rm_async_req", 32'(mem_req),   32'h0);
      check("rm_reg",       32'(reg_value), 32'h0);
      check("rm_dirty",     32'(dirty),     32'h0);
      check("rm_head",      32'(head_addr), 32'h0);
      check("rm_ready",     32'(cmd_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rm_post_req",   32'(mem_req),   32'h0);
      check("rm_post_ready", 32'(cmd_ready), 32'h1);
      check("rm_post_head",  32'(head_addr), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
